// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Registered round-robin arbiter for the NoC switch response path. One
//   instance serves read responses (high priority), a second instance serves
//   all other responses. Request bit N-1 corresponds to device 0x40 and the
//   remaining bits descend from there.
//
//   A pointer names the requester that is examined first. The search runs
//   downward from the pointer and wraps from 0 back to N-1. The winner's grant
//   is registered, and the pointer moves to just below the winner, so the
//   winner has the lowest priority at the next arbitration.
//
// Ports
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous reset, active low
//   en           in   1          arbitration enable; state holds when low
//   req          in   N          level-sensitive request vector
//   grant        out  N          registered one-hot grant, zero when idle
//   grant_valid  out  1          registered, high when grant is non-zero
//   grant_idx    out  clog2(N)   registered binary index of the grant, 0 when idle
//
// Handshake: there is no valid/ready pair. A requester holds its req bit until
//   it sees its grant bit, then it may drop the bit. A request that is
//   withdrawn before an enabled edge is simply not considered.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  r_grant;
    logic          r_valid;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_ptr;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [N-1:0]  w_onehot;
    logic [IW-1:0] w_next_ptr;

    // Downward search from r_ptr with wrap. k is the candidate index for
    // step i. It is brought back into 0..N-1 by adding N, so non-power-of-two
    // N works as well.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(r_ptr) - i;
            if (k < 0) begin
                k = k + N;
            end
            if (!w_found && req[k]) begin
                w_found = 1'b1;
                w_win   = IW'(k);
            end
        end
    end

    assign w_onehot   = N'(1) << w_win;
    // The winner becomes the lowest priority: the search next starts one below it.
    assign w_next_ptr = (w_win == '0) ? IW'(N - 1) : (w_win - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= IW'(N - 1);
        end else if (en) begin
            if (w_found) begin
                r_grant <= w_onehot;
                r_valid <= 1'b1;
                r_idx   <= w_win;
                r_ptr   <= w_next_ptr;
            end else begin
                // Idle: outputs clear and the pointer keeps its place.
                r_grant <= '0;
                r_valid <= 1'b0;
                r_idx   <= '0;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int W  = N + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  req = '0;
  logic          en = 1'b0;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  logic [N-1:0]  lp_req = '0;
  logic          lp_en = 1'b0;
  logic [N-1:0]  lp_grant;
  logic          lp_grant_valid;
  logic [IW-1:0] lp_grant_idx;

  rr_arbiter #(.N(N)) u_hp (
    .clk(clk), .reset(reset), .en(en), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  rr_arbiter #(.N(N)) u_lp (
    .clk(clk), .reset(reset), .en(lp_en), .req(lp_req),
    .grant(lp_grant), .grant_valid(lp_grant_valid), .grant_idx(lp_grant_idx)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic          mon_on = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: scans a doubled copy of req from bit ptr+N down to ptr+1.
  logic [IW-1:0] m_ptr = IW'(N - 1);
  logic [W-1:0]  m_out = '0;

  task automatic model_step(input logic [N-1:0] r, input logic e, output logic [W-1:0] o);
    logic [2*N-1:0] dbl;
    int w;
    bit found;
    dbl = {r, r};
    found = 0;
    w = 0;
    if (!e) begin
      o = m_out;
    end else if (r == '0) begin
      o = '0;
    end else begin
      for (int b = int'(m_ptr) + N; b > int'(m_ptr); b--) begin
        if (!found && dbl[b]) begin
          found = 1;
          w = b % N;
        end
      end
      o = {1'b1, IW'(w), N'(1 << w)};
      m_ptr = IW'((w + N - 1) % N);
    end
    m_out = o;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] r, input logic e, input string tag);
    logic [W-1:0] o;
    @(negedge clk);
    req = r;
    en = e;
    model_step(r, e, o);
    exp_q.push_back(o);
    @(posedge clk);
    #1;
    check_val(tag, {grant_valid, grant_idx, grant}, exp_q.pop_front());
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    req = '1;
    en = 1'b1;
    #1;
    check_val({tag, "_grant"}, grant, 0);
    check_val({tag, "_valid"}, grant_valid, 0);
    check_val({tag, "_idx"}, grant_idx, 0);
    m_ptr = IW'(N - 1);
    m_out = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val({tag, "_hold"}, {grant_valid, grant_idx, grant}, 0);
    @(negedge clk);
    en = 1'b0;
    req = '0;
    reset = 1'b1;
  endtask

  // One-hot-or-zero on every cycle, both instances.
  always @(negedge clk) begin
    if (mon_on) begin
      check_val("onehot_hp", $onehot0(grant), 1);
      check_val("onehot_lp", $onehot0(lp_grant), 1);
    end
  end

  logic [N-1:0] rot_tbl[5];
  logic [N-1:0] skip_tbl[4];
  logic [IW-1:0] hp_order_q[$];
  logic [IW-1:0] lp_order_q[$];

  initial begin
    int hp_n;
    int lp_n;
    rot_tbl  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    skip_tbl = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};

    // 1. reset
    do_reset("rst0");

    // 2. rotation
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, "rot");
      check_val("rot_const", grant, rot_tbl[i]);
      check_val("rot_idx", grant_idx, 3 - (i % 4));
    end

    // 1 again, now with a live grant; then 3. skip idle requesters
    do_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 1'b1, "skip");
      check_val("skip_const", grant, skip_tbl[i]);
      check_val("skip_valid", grant_valid, 1);
    end

    // 4. idle keeps pointer
    step(4'b0101, 1'b1, "pre_idle");
    check_val("pre_idle_const", grant, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1, "idle");
      check_val("idle_const", {grant_valid, grant}, 0);
    end
    step(4'b1111, 1'b1, "after_idle");
    check_val("after_idle_const", grant, 4'b0010);

    // 5. enable gating
    step(4'b1111, 1'b1, "pre_en");
    step(4'b1111, 1'b1, "pre_en2");
    check_val("pre_en_const", grant, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b0, "en_hold");
      check_val("en_hold_const", grant, 4'b1000);
    end
    step(4'b1111, 1'b1, "en_resume");
    check_val("en_resume_const", grant, 4'b0100);

    // Wrap-around: ptr=0 with only req[N-1]
    step(4'b0010, 1'b1, "wrap_setup");
    step(4'b1000, 1'b1, "wrap");
    check_val("wrap_const", grant, 4'b1000);
    step(4'b1111, 1'b1, "wrap_ptr");
    check_val("wrap_ptr_const", grant, 4'b0100);

    // Random stimulus against the model
    for (int i = 0; i < 300; i++) begin
      step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0), "rand");
    end

    // Reset mid-stream: first arbitration starts again from N-1
    do_reset("rst_mid");
    step(4'b1111, 1'b1, "post_rst");
    check_val("post_rst_const", grant, 4'b1000);

    // 6. HP/LP pair, requesters clear after grant
    do_reset("rst_pair");
    hp_order_q = '{2'd3, 2'd2, 2'd1, 2'd0};
    lp_order_q = '{2'd2, 2'd0};
    hp_n = 0;
    lp_n = 0;
    @(negedge clk);
    req = 4'b1111;
    lp_req = 4'b0101;
    en = 1'b1;
    lp_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (grant_valid) begin
        hp_n++;
        if (hp_order_q.size() == 0) check_val("hp_extra", grant_idx, 4'hf);
        else check_val("hp_order", grant_idx, hp_order_q.pop_front());
      end
      if (lp_grant_valid) begin
        lp_n++;
        if (lp_order_q.size() == 0) check_val("lp_extra", lp_grant_idx, 4'hf);
        else check_val("lp_order", lp_grant_idx, lp_order_q.pop_front());
      end
      @(negedge clk);
      req = req & ~grant;
      lp_req = lp_req & ~lp_grant;
    end
    check_val("hp_count", hp_n, 4);
    check_val("lp_count", lp_n, 2);
    check_val("hp_final_idle", grant_valid, 0);
    check_val("lp_final_idle", lp_grant_valid, 0);

    mon_on = 1'b0;
    check_val("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
